rr_grant_ctrl: RTL

Round-robin grant controller that shares one resource among eight requesters driven from the board switches. It replaces fixed-priority selection with a fair, time-bounded scheme. Each grant is limited to MAX_GRANT cycles, and the granted requester's index is shown on a seven-segment digit. The block sits between the switch/request inputs and the LED/seven-segment outputs in the NPC board top.

---
 rtl/rr_grant_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: shares one resource among eight level-sensitive
// requesters. Each grant lasts at most MAX_GRANT cycles and is followed by at least
// one idle cycle. The granted index is also shown on an active-low seven-segment digit.
module rr_grant_ctrl #(
    parameter int unsigned MAX_GRANT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       valid,
    output logic [6:0] seg0
);

    // Grant age counter is wide enough to hold MAX_GRANT-1, at least one bit.
    localparam int unsigned CntW = (MAX_GRANT > 1) ? $clog2(MAX_GRANT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MAX_GRANT - 1);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StGrant = 1'b1;

    localparam logic [6:0] SegBlank = 7'b1111111;

    logic [0:0]      state_q, state_d;
    logic [7:0]      gnt_q, gnt_d;
    logic [2:0]      gnt_idx_q, gnt_idx_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            sel_found;
    logic [2:0]      sel_idx;
    logic [2:0]      cand;
    logic            release_now;

    // Search req starting at ptr and wrapping 7->0; the first set bit wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr_q;
        cand      = ptr_q;
        // Walk offsets from farthest to nearest so the nearest set bit is written last.
        for (int i = 7; i >= 0; i--) begin
            cand = ptr_q + 3'(i);
            if (req[cand]) begin
                sel_idx   = cand;
                sel_found = 1'b1;
            end
        end
    end

    // Any one of: owner dropped its request, grant reached its age limit, or disabled.
    always_comb begin
        release_now = (!en) || (!req[gnt_idx_q]) || (cnt_q == CntLast);
    end

    // Next-state logic for the IDLE/GRANT machine and its datapath registers.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (en && sel_found) begin
                    state_d   = StGrant;
                    gnt_d     = 8'b1 << sel_idx;
                    gnt_idx_d = sel_idx;
                    cnt_d     = '0;
                end
            end
            StGrant: begin
                if (release_now) begin
                    // gnt_idx is left stale; valid=0 masks it.
                    state_d = StIdle;
                    gnt_d   = '0;
                    ptr_d   = gnt_idx_q + 3'd1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous, active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign valid   = |gnt_q;

    // Active-low seven-segment decode of the registered index; blank when idle.
    always_comb begin
        seg0 = SegBlank;
        if (valid) begin
            unique case (gnt_idx_q)
                3'd0:    seg0 = 7'b0000001;
                3'd1:    seg0 = 7'b1001111;
                3'd2:    seg0 = 7'b0010010;
                3'd3:    seg0 = 7'b0000110;
                3'd4:    seg0 = 7'b1001100;
                3'd5:    seg0 = 7'b0100100;
                3'd6:    seg0 = 7'b0100000;
                3'd7:    seg0 = 7'b0001111;
                default: seg0 = SegBlank;
            endcase
        end
    end

endmodule
